// File: rtl/dest_reg_file_if.sv
// Request/response bundle for dest_reg_file: one write port, two read ports, clear control and status.
interface dest_reg_file_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    // Every *_en / clr_req is a single-cycle request taken at the rising edge. There is no
    // ready signal: while busy=1, writes are dropped and clr_req is ignored. Reads are always taken.
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en_a;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    logic              rd_hit_a;
    logic              rd_en_b;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;
    logic              rd_hit_b;
    logic              clr_req;
    logic              busy;
    logic [ADDR_W:0]   valid_cnt;

    modport master (
        output wr_en, wr_addr, wr_data,
        output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        output clr_req,
        input  rd_data_a, rd_hit_a, rd_data_b, rd_hit_b,
        input  busy, valid_cnt
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        input  clr_req,
        output rd_data_a, rd_hit_a, rd_data_b, rd_hit_b,
        output busy, valid_cnt
    );
endinterface

// File: rtl/dest_reg_file.sv
// Register file with one write port, two registered read ports and a one-entry-per-cycle clear sweep.
// Define DEST_REG_BYPASS_EN to forward an accepted same-edge write to a read of the same address.
module dest_reg_file #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    dest_reg_file_if.slave bus,
    output logic           fsm_state
);
    localparam int DEPTH = 1 << ADDR_W;

`ifdef DEST_REG_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              busy_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [ADDR_W:0]   cnt;
    logic [DATA_W-1:0] rd_data_a_q;
    logic [DATA_W-1:0] rd_data_b_q;
    logic              rd_hit_a_q;
    logic              rd_hit_b_q;
    logic              wr_acc;
    logic              byp_a;
    logic              byp_b;

    assign wr_acc = bus.wr_en && !busy_q;
    assign byp_a  = BYPASS && wr_acc && (bus.wr_addr == bus.rd_addr_a);
    assign byp_b  = BYPASS && wr_acc && (bus.wr_addr == bus.rd_addr_b);

    // ptr wraps to 0 on its own after the last entry, so the next clear starts from 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= '0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clr_req) begin
                        state  <= SWEEP;
                        ptr    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                SWEEP: begin
                    ptr <= ptr + 1'b1;
                    if (&ptr) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Writes and sweep clears are mutually exclusive, so the count moves by at most one per edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            valid <= '0;
            cnt   <= '0;
        end else if (busy_q) begin
            mem[ptr]   <= '0;
            valid[ptr] <= 1'b0;
            if (valid[ptr]) begin
                cnt <= cnt - 1'b1;
            end
        end else if (wr_acc) begin
            mem[bus.wr_addr]   <= bus.wr_data;
            valid[bus.wr_addr] <= 1'b1;
            if (!valid[bus.wr_addr]) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_a_q <= '0;
            rd_hit_a_q  <= 1'b0;
        end else if (bus.rd_en_a) begin
            rd_data_a_q <= byp_a ? bus.wr_data : mem[bus.rd_addr_a];
            rd_hit_a_q  <= byp_a ? 1'b1 : valid[bus.rd_addr_a];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_b_q <= '0;
            rd_hit_b_q  <= 1'b0;
        end else if (bus.rd_en_b) begin
            rd_data_b_q <= byp_b ? bus.wr_data : mem[bus.rd_addr_b];
            rd_hit_b_q  <= byp_b ? 1'b1 : valid[bus.rd_addr_b];
        end
    end

    assign bus.rd_data_a = rd_data_a_q;
    assign bus.rd_hit_a  = rd_hit_a_q;
    assign bus.rd_data_b = rd_data_b_q;
    assign bus.rd_hit_b  = rd_hit_b_q;
    assign bus.busy      = busy_q;
    assign bus.valid_cnt = cnt;
    assign fsm_state     = (state == SWEEP);
endmodule

// File: tb/tb_dest_reg_file.sv
// Directed bench for dest_reg_file with a reference model compared every cycle.
module tb_dest_reg_file;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 1 << ADDR_W;

`ifdef DEST_REG_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic fsm_state;
    int   n_vec;
    int   n_err;

    dest_reg_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    dest_reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_vec=%0d n_err=%0d", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] m_mem [DEPTH];
    bit                m_valid [DEPTH];
    int                sweep_left;
    logic [DATA_W-1:0] m_rd_a, m_rd_b;
    bit                m_hit_a, m_hit_b;
    bit                model_live = 1'b0;
    bit                wr_ok;
    int                idx;
    int                m_cnt;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i]   = '0;
                m_valid[i] = 1'b0;
            end
            sweep_left = 0;
            m_rd_a = '0; m_rd_b = '0; m_hit_a = 1'b0; m_hit_b = 1'b0;
            model_live = 1'b1;
        end else if (model_live) begin
            wr_ok = bus.wr_en && (sweep_left == 0);
            if (bus.rd_en_a) begin
                if (BYP && wr_ok && bus.wr_addr == bus.rd_addr_a) begin
                    m_rd_a = bus.wr_data; m_hit_a = 1'b1;
                end else begin
                    m_rd_a = m_mem[bus.rd_addr_a]; m_hit_a = m_valid[bus.rd_addr_a];
                end
            end
            if (bus.rd_en_b) begin
                if (BYP && wr_ok && bus.wr_addr == bus.rd_addr_b) begin
                    m_rd_b = bus.wr_data; m_hit_b = 1'b1;
                end else begin
                    m_rd_b = m_mem[bus.rd_addr_b]; m_hit_b = m_valid[bus.rd_addr_b];
                end
            end
            if (sweep_left > 0) begin
                idx = DEPTH - sweep_left;
                m_mem[idx]   = '0;
                m_valid[idx] = 1'b0;
                sweep_left--;
            end else begin
                if (wr_ok) begin
                    m_mem[bus.wr_addr]   = bus.wr_data;
                    m_valid[bus.wr_addr] = 1'b1;
                end
                if (bus.clr_req) sweep_left = DEPTH;
            end
        end
        #1;
        if (model_live) begin
            m_cnt = 0;
            for (int i = 0; i < DEPTH; i++) m_cnt += int'(m_valid[i]);
            check("model rd_data_a", 32'(bus.rd_data_a), 32'(m_rd_a));
            check("model rd_hit_a",  32'(bus.rd_hit_a),  32'(m_hit_a));
            check("model rd_data_b", 32'(bus.rd_data_b), 32'(m_rd_b));
            check("model rd_hit_b",  32'(bus.rd_hit_b),  32'(m_hit_b));
            check("model busy",      32'(bus.busy),      32'(sweep_left > 0));
            check("model fsm_state", 32'(fsm_state),     32'(sweep_left > 0));
            check("model valid_cnt", 32'(bus.valid_cnt), 32'(m_cnt));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_en_a = 1'b0; bus.rd_addr_a = '0;
        bus.rd_en_b = 1'b0; bus.rd_addr_b = '0;
        bus.clr_req = 1'b0;
    endtask

    task automatic write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic read_ab(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        bus.rd_en_a = 1'b1; bus.rd_addr_a = a;
        bus.rd_en_b = 1'b1; bus.rd_addr_b = b;
        tick();
        bus.rd_en_a = 1'b0; bus.rd_en_b = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    int n_busy;

    initial begin
        n_vec = 0;
        n_err = 0;
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        tick();
        tick();
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset valid_cnt", 32'(bus.valid_cnt), 32'd0);
        check("reset rd_data_a", 32'(bus.rd_data_a), 32'd0);
        rst_n = 1'b1;

        for (int a = 0; a < DEPTH; a++) begin
            read_ab(ADDR_W'(a), ADDR_W'(DEPTH - 1 - a));
            check("post-reset read data", 32'(bus.rd_data_a), 32'd0);
            check("post-reset read hit", 32'(bus.rd_hit_a), 32'd0);
        end
        check("post-reset valid_cnt", 32'(bus.valid_cnt), 32'd0);

        write(3'd3, 16'h1234);
        write(3'd7, 16'hBEEF);
        read_ab(3'd3, 3'd7);
        check("wr/rd data_a", 32'(bus.rd_data_a), 32'h1234);
        check("wr/rd data_b", 32'(bus.rd_data_b), 32'hBEEF);
        check("wr/rd hit_a", 32'(bus.rd_hit_a), 32'd1);
        check("wr/rd hit_b", 32'(bus.rd_hit_b), 32'd1);
        check("wr/rd valid_cnt", 32'(bus.valid_cnt), 32'd2);
        write(3'd3, 16'h5555);
        check("rewrite valid_cnt", 32'(bus.valid_cnt), 32'd2);
        tick();
        check("hold data_a", 32'(bus.rd_data_a), 32'h1234);
        read_ab(3'd3, 3'd3);
        check("same addr data_a", 32'(bus.rd_data_a), 32'h5555);
        check("same addr data_b", 32'(bus.rd_data_b), 32'h5555);

        write(3'd5, 16'h0A0A);
        bus.rd_en_a = 1'b1; bus.rd_addr_a = 3'd5;
        write(3'd5, 16'h5A5A);
        bus.rd_en_a = 1'b0;
        check("bypass data_a", 32'(bus.rd_data_a), BYP ? 32'h5A5A : 32'h0A0A);
        check("bypass hit_a", 32'(bus.rd_hit_a), 32'd1);
        read_ab(3'd5, 3'd0);
        check("after bypass data_a", 32'(bus.rd_data_a), 32'h5A5A);

        bus.rd_en_a = 1'b1; bus.rd_addr_a = 3'd6;
        write(3'd6, 16'h0001);
        bus.rd_en_a = 1'b0;
        check("fresh bypass data_a", 32'(bus.rd_data_a), BYP ? 32'h0001 : 32'h0000);
        check("fresh bypass hit_a", 32'(bus.rd_hit_a), BYP ? 32'd1 : 32'd0);
        check("fresh valid_cnt", 32'(bus.valid_cnt), 32'd4);

        for (int a = 0; a < DEPTH; a++) write(ADDR_W'(a), DATA_W'(16'h1100 + a));
        check("full valid_cnt", 32'(bus.valid_cnt), 32'd8);
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        n_busy = 0;
        while (bus.busy && n_busy < 20) begin
            n_busy++;
            bus.wr_en = 1'b1; bus.wr_addr = ADDR_W'(n_busy); bus.wr_data = 16'hDEAD;
            bus.rd_en_a = 1'b1; bus.rd_addr_a = ADDR_W'(n_busy);
            tick();
        end
        idle_inputs();
        check("clear busy cycles", 32'(n_busy), 32'd8);
        check("clear valid_cnt", 32'(bus.valid_cnt), 32'd0);
        for (int a = 0; a < DEPTH; a++) begin
            read_ab(ADDR_W'(a), ADDR_W'(a));
            check("cleared data", 32'(bus.rd_data_a), 32'd0);
            check("cleared hit", 32'(bus.rd_hit_b), 32'd0);
        end

        write(3'd1, 16'h0011);
        write(3'd6, 16'h0066);
        bus.clr_req = 1'b1;
        bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 16'h2222;
        tick();
        idle_inputs();
        check("clr+wr valid_cnt", 32'(bus.valid_cnt), 32'd3);
        check("clr+wr busy", 32'(bus.busy), 32'd1);
        tick();
        tick();
        tick();
        check("mid-sweep valid_cnt", 32'(bus.valid_cnt), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort state", 32'(fsm_state), 32'd0);
        check("abort valid_cnt", 32'(bus.valid_cnt), 32'd0);
        read_ab(3'd6, 3'd2);
        check("abort read hit_a", 32'(bus.rd_hit_a), 32'd0);

        write(3'd4, 16'h4444);
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        n_busy = 0;
        while (bus.busy && n_busy < 20) begin
            n_busy++;
            bus.clr_req = (n_busy == 3);
            tick();
        end
        idle_inputs();
        check("re-clr busy cycles", 32'(n_busy), 32'd8);
        tick();
        tick();
        check("re-clr not queued", 32'(bus.busy), 32'd0);
        check("re-clr valid_cnt", 32'(bus.valid_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
